operand_fetch: RTL and testbench

//  Issue stage between decode and execute. Reads the register file and

---
 rtl/operand_fetch.sv | 118 +++++++++++
 tb/tb_operand_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Issue stage: reads register operands, forwards same-cycle writeback, tracks busy
// destinations in a scoreboard and presents one registered slot to execute.
module operand_fetch #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr,
  output logic [REG_AW-1:0] rf_rin1,
  output logic [REG_AW-1:0] rf_rin2,
  input  logic [XLEN-1:0]   rf_rs1,
  input  logic [XLEN-1:0]   rf_rs2,
  output logic              rf_en,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_data,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]   busy_reg, busy_next;
  logic              out_valid_reg;
  logic [XLEN-1:0]   out_instr_reg, out_op1_reg, out_op2_reg;
  logic [REG_AW-1:0] out_rd_reg;
  logic              out_wr_reg;

  logic              fwd1, fwd2, haz1, haz2, waw, slot_free, issue, wr_next;
  logic [XLEN-1:0]   op1_next, op2_next;

  assign rf_rin1 = in_rs1;
  assign rf_rin2 = in_rs2;
  assign rf_en   = wb_valid && (wb_rd != '0);
  assign rf_rd   = wb_rd;
  assign rf_data = wb_data;

  assign fwd1     = wb_valid && (wb_rd == in_rs1) && (in_rs1 != '0);
  assign fwd2     = wb_valid && (wb_rd == in_rs2) && (in_rs2 != '0);
  assign op1_next = (in_rs1 == '0) ? '0 : (fwd1 ? wb_data : rf_rs1);
  assign op2_next = (in_rs2 == '0) ? '0 : (fwd2 ? wb_data : rf_rs2);

  // A source being written back this very cycle is not a hazard: it is forwarded.
  assign haz1 = in_use1 && (in_rs1 != '0) && busy_reg[in_rs1] && !fwd1;
  assign haz2 = in_use2 && (in_rs2 != '0) && busy_reg[in_rs2] && !fwd2;
  assign waw  = in_wr && (in_rd != '0) && busy_reg[in_rd] &&
                !(wb_valid && (wb_rd == in_rd));

  assign slot_free = !out_valid_reg || out_ready;
  assign in_ready  = !flush && slot_free && !haz1 && !haz2 && !waw;
  assign issue     = in_valid && in_ready;
  assign wr_next   = in_wr && (in_rd != '0);

  // Per-register scoreboard: an issue set outranks a writeback or flush clear.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
        logic set_bit, clr_bit;
        assign set_bit = issue && wr_next && (in_rd == IDX);
        assign clr_bit = (wb_valid && (wb_rd == IDX)) ||
                         (flush && out_valid_reg && out_wr_reg && (out_rd_reg == IDX));
        assign busy_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_op1_reg   <= '0;
      out_op2_reg   <= '0;
      out_rd_reg    <= '0;
      out_wr_reg    <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      if (issue) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= in_instr;
        out_op1_reg   <= op1_next;
        out_op2_reg   <= op2_next;
        out_rd_reg    <= in_rd;
        out_wr_reg    <= wr_next;
      end else if (flush || out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_op1   = out_op1_reg;
  assign out_op2   = out_op2_reg;
  assign out_rd    = out_rd_reg;
  assign out_wr    = out_wr_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a table of single-issue vectors followed by
// hand-written hazard, backpressure, flush and reset sequences.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use1, in_use2, in_wr;
  logic [4:0]  rf_rin1, rf_rin2;
  logic [31:0] rf_rs1, rf_rs2;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_wr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
    .in_rd(in_rd), .in_wr(in_wr),
    .rf_rin1(rf_rin1), .rf_rin2(rf_rin2), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_wr(out_wr)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
    logic        fl;
    logic        exp_ready, exp_rf_en, exp_valid;
    logic [31:0] exp_op1, exp_op2;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{5'd3,  5'd4,  32'h11111111, 32'h22222222, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 32'h22222222};
    vecs[1] = '{5'd0,  5'd7,  32'hDEAD,     32'h77,       1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h77};
    vecs[2] = '{5'd5,  5'd6,  32'hA,        32'hB,        1'b1, 5'd5,  32'h55,   1'b0, 1'b1, 1'b1, 1'b1, 32'h55,       32'hB};
    vecs[3] = '{5'd9,  5'd9,  32'h1,        32'h2,        1'b1, 5'd9,  32'h99,   1'b0, 1'b1, 1'b1, 1'b1, 32'h99,       32'h99};
    vecs[4] = '{5'd0,  5'd0,  32'h3,        32'h4,        1'b1, 5'd0,  32'h123,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[5] = '{5'd1,  5'd2,  32'h5,        32'h6,        1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[6] = '{5'd31, 5'd2,  32'hFFFFFFFF, 32'h2,        1'b1, 5'd2,  32'hCAFE, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hCAFE};
    vecs[7] = '{5'd30, 5'd31, 32'h30,       32'h1,        1'b1, 5'd31, 32'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h30,       32'hBEEF};

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs1 = '0; in_rs2 = '0;
    in_use1 = 1'b0; in_use2 = 1'b0; in_rd = '0; in_wr = 1'b0;
    rf_rs1 = '0; rf_rs2 = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_out_instr", out_instr, 32'h0);
    chk("reset_out_op1", out_op1, 32'h0);
    chk("reset_out_op2", out_op2, 32'h0);
    chk("reset_out_rd_wr", {26'b0, out_rd, out_wr}, 32'h0);
    chk("reset_busy", dut.busy_reg, 32'h0);

    // Table: single issues with no destination, so the scoreboard stays empty.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = 32'h1000 + i; in_wr = 1'b0; in_rd = '0;
      in_use1 = 1'b1; in_use2 = 1'b1;
      in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
      rf_rs1 = vecs[i].rf1; rf_rs2 = vecs[i].rf2;
      wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbdata;
      flush = vecs[i].fl; out_ready = 1'b1;
      #1;
      chk("vec_in_ready", {31'b0, in_ready}, {31'b0, vecs[i].exp_ready});
      chk("vec_rf_en", {31'b0, rf_en}, {31'b0, vecs[i].exp_rf_en});
      chk("vec_rf_rin", {22'b0, rf_rin1, rf_rin2}, {22'b0, vecs[i].rs1, vecs[i].rs2});
      chk("vec_rf_wb", rf_data ^ {27'b0, rf_rd}, vecs[i].wbdata ^ {27'b0, vecs[i].wbrd});
      step();
      chk("vec_out_valid", {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk("vec_out_op1", out_op1, vecs[i].exp_op1);
        chk("vec_out_op2", out_op2, vecs[i].exp_op2);
        chk("vec_out_instr", out_instr, 32'h1000 + i);
      end
      $display("vec %0d: rs1=%0d rs2=%0d op1=0x%0h op2=0x%0h valid=%0b", i,
               vecs[i].rs1, vecs[i].rs2, out_op1, out_op2, out_valid);
    end
    in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    step();
    chk("table_busy", dut.busy_reg, 32'h0);

    // addi x1 then dependent add x2,x1,x1 resolved by forwarding.
    in_valid = 1'b1; in_instr = 32'h00100093; in_rd = 5'd1; in_wr = 1'b1;
    in_rs1 = 5'd0; in_use1 = 1'b1; in_use2 = 1'b0; in_rs2 = 5'd0;
    #1 chk("addi_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("addi_out_valid", {31'b0, out_valid}, 32'h1);
    chk("addi_out_rd_wr", {26'b0, out_rd, out_wr}, {26'b0, 5'd1, 1'b1});
    chk("addi_busy", dut.busy_reg, 32'h2);
    $display("seq addi x1 issued");
    in_instr = 32'h00108133; in_rd = 5'd2; in_rs1 = 5'd1; in_rs2 = 5'd1;
    in_use1 = 1'b1; in_use2 = 1'b1; rf_rs1 = 32'h1234; rf_rs2 = 32'h5678;
    #1 chk("raw_stall", {31'b0, in_ready}, 32'h0);
    step();
    chk("raw_slot_drained", {31'b0, out_valid}, 32'h0);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    #1 chk("raw_fwd_ready", {31'b0, in_ready}, 32'h1);
    chk("raw_rf_en", {31'b0, rf_en}, 32'h1);
    step();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("fwd_op1", out_op1, 32'h55);
    chk("fwd_op2", out_op2, 32'h55);
    chk("fwd_busy", dut.busy_reg, 32'h4);
    $display("seq add x2,x1,x1 issued op1=0x%0h op2=0x%0h", out_op1, out_op2);

    // Writeback to x0.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    #1 chk("wb_x0_rf_en", {31'b0, rf_en}, 32'h0);
    step();
    wb_valid = 1'b0;
    chk("wb_x0_busy", dut.busy_reg, 32'h4);

    // Backpressure: slot must hold for three cycles while rf inputs change.
    in_valid = 1'b1; in_instr = 32'hC; in_rd = 5'd0; in_wr = 1'b0;
    in_rs1 = 5'd3; in_rs2 = 5'd4; rf_rs1 = 32'h33; rf_rs2 = 32'h44;
    step();
    in_instr = 32'hD; in_rs1 = 5'd5; rf_rs1 = 32'h5555; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold_in_ready", {31'b0, in_ready}, 32'h0);
      step();
      chk("hold_out_valid", {31'b0, out_valid}, 32'h1);
      chk("hold_out_instr", out_instr, 32'hC);
      chk("hold_out_op1", out_op1, 32'h33);
      $display("hold cycle %0d: out_instr=0x%0h", c, out_instr);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("release_instr", out_instr, 32'hD);
    chk("release_op1", out_op1, 32'h5555);

    // Flush of a slot that writes x5.
    in_instr = 32'hE; in_rd = 5'd5; in_wr = 1'b1; in_use1 = 1'b0; in_use2 = 1'b0;
    step();
    chk("flush_pre_busy", dut.busy_reg, 32'h24);
    in_instr = 32'hF; in_rd = 5'd6; flush = 1'b1; out_ready = 1'b0;
    #1 chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_busy", dut.busy_reg, 32'h4);
    $display("seq flush done busy=0x%0h", dut.busy_reg);

    // WAW on x1: stalls until writeback, issue in the wb cycle keeps busy set.
    in_instr = 32'h6; in_rd = 5'd1; in_wr = 1'b1;
    step();
    chk("waw_first_busy", dut.busy_reg, 32'h6);
    in_instr = 32'h7;
    #1 chk("waw_stall", {31'b0, in_ready}, 32'h0);
    step();
    chk("waw_slot_drained", {31'b0, out_valid}, 32'h0);
    #1 chk("waw_stall2", {31'b0, in_ready}, 32'h0);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h9;
    #1 chk("waw_wb_ready", {31'b0, in_ready}, 32'h1);
    step();
    wb_valid = 1'b0;
    chk("waw_busy_kept", dut.busy_reg, 32'h6);
    chk("waw_out_instr", out_instr, 32'h7);
    chk("waw_out_valid", {31'b0, out_valid}, 32'h1);
    $display("seq waw x1 issued in wb cycle");

    // Reset beats a concurrent issue.
    reset = 1'b1; in_instr = 32'h8; in_rd = 5'd3;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("reset_wins_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_wins_busy", dut.busy_reg, 32'h0);
    chk("reset_wins_instr", out_instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
